// File: rtl/machine_ctrl.sv
// rtl/machine_ctrl.sv - instruction-sequencing FSM for the 8-bit accumulator CPU
module machine_ctrl #(
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       ir_sel,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt,
  output logic       bus_err
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, F_HI, F_LO, DECODE, EXEC, SKIP, HALTED, ERR
  } state_t;

  state_t           state, state_nx, done_st;
  logic [2:0]       opc_q;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic             stall;
  logic             timeout;

  // State, latched opcode and stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opc_q    <= OP_HLT;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (state == DECODE) begin
        opc_q <= opcode;
      end
    end
  end

  // Next-state logic and one-cycle control strobes
  always_comb begin
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    ir_sel      = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    bus_err     = 1'b0;
    stall       = 1'b0;
    state_nx    = state;
    // Instruction boundary: ena is only consulted here
    done_st     = ena ? F_HI : IDLE;

    case (state)
      IDLE: begin
        if (ena) state_nx = F_HI;
      end
      F_HI, F_LO: begin
        rd = 1'b1;
        if (mem_rdy) begin
          load_ir  = 1'b1;
          ir_sel   = (state == F_LO);
          inc_pc   = 1'b1;
          state_nx = (state == F_HI) ? F_LO : DECODE;
        end else begin
          stall = 1'b1;
        end
      end
      DECODE: begin
        state_nx = (opcode == OP_HLT) ? HALTED : EXEC;
      end
      EXEC: begin
        case (opc_q)
          OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
            rd = 1'b1;
            if (mem_rdy) begin
              load_acc = 1'b1;
              state_nx = done_st;
            end else begin
              stall = 1'b1;
            end
          end
          OP_STO: begin
            wr          = 1'b1;
            datactl_ena = 1'b1;
            if (mem_rdy) state_nx = done_st;
            else         stall    = 1'b1;
          end
          OP_JMP: begin
            load_pc  = 1'b1;
            state_nx = done_st;
          end
          OP_SKZ: begin
            if (zero) begin
              inc_pc   = 1'b1;
              state_nx = SKIP;
            end else begin
              state_nx = done_st;
            end
          end
          default: state_nx = HALTED;  // HLT never reaches EXEC
        endcase
      end
      SKIP: begin
        inc_pc   = 1'b1;
        state_nx = done_st;
      end
      HALTED: begin
        halt = 1'b1;
      end
      ERR: begin
        halt    = 1'b1;
        bus_err = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // Watchdog: WAIT_MAX stalls are tolerated, one more is a bus error
    timeout = stall && (WAIT_MAX > 0) && (wait_cnt == WAIT_LIM);
    if (timeout) state_nx = ERR;

    // Counter only runs while a memory access is stalled in place
    if (stall && !timeout) begin
      wait_cnt_nx = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_ONE;
    end else begin
      wait_cnt_nx = '0;
    end
  end

endmodule

// File: tb/tb_machine_ctrl.sv
// tb/tb_machine_ctrl.sv - directed self-checking bench for machine_ctrl
module tb_machine_ctrl;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, LDA = 3'b101,
                         STO = 3'b110, JMP = 3'b111;

  // Output vector bit positions {rd,wr,load_ir,ir_sel,inc_pc,load_pc,load_acc,datactl_ena,halt,bus_err}
  localparam logic [9:0] O_RD   = 10'b10_0000_0000;
  localparam logic [9:0] O_WR   = 10'b01_0000_0000;
  localparam logic [9:0] O_LIR  = 10'b00_1000_0000;
  localparam logic [9:0] O_SEL  = 10'b00_0100_0000;
  localparam logic [9:0] O_INC  = 10'b00_0010_0000;
  localparam logic [9:0] O_LPC  = 10'b00_0001_0000;
  localparam logic [9:0] O_LACC = 10'b00_0000_1000;
  localparam logic [9:0] O_DCE  = 10'b00_0000_0100;
  localparam logic [9:0] O_HALT = 10'b00_0000_0010;
  localparam logic [9:0] O_BERR = 10'b00_0000_0001;
  localparam logic [9:0] O_NONE = 10'b00_0000_0000;
  localparam logic [9:0] X_FHI  = O_RD | O_LIR | O_INC;
  localparam logic [9:0] X_FLO  = O_RD | O_LIR | O_SEL | O_INC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [2:0] opcode = HLT;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b1;
  logic       rd, wr, load_ir, ir_sel, inc_pc, load_pc, load_acc, datactl_ena, halt, bus_err;
  logic [9:0] outs;

  int tests_run = 0;
  int tests_failed = 0;

  machine_ctrl #(.WAIT_MAX(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy),
    .rd(rd), .wr(wr), .load_ir(load_ir), .ir_sel(ir_sel), .inc_pc(inc_pc),
    .load_pc(load_pc), .load_acc(load_acc), .datactl_ena(datactl_ena),
    .halt(halt), .bus_err(bus_err)
  );

  assign outs = {rd, wr, load_ir, ir_sel, inc_pc, load_pc, load_acc, datactl_ena, halt, bus_err};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs just after a rising edge, check outputs at the falling edge
  task automatic cyc(input string tag, input logic r, input logic e, input logic rdy,
                     input logic z, input logic [2:0] op, input logic [9:0] exp);
    @(posedge clk);
    #1;
    rst = r; ena = e; mem_rdy = rdy; zero = z; opcode = op;
    @(negedge clk);
    check(tag, outs, exp);
  endtask

  initial begin
    // Reset, then idle with ena low
    cyc("rst_cycle_a", 1, 0, 1, 0, HLT, outs);
    tests_run--;
    cyc("reset_state", 0, 0, 1, 0, HLT, O_NONE);
    cyc("idle_ena", 0, 1, 1, 0, HLT, O_NONE);

    // LDA with mem_rdy=1: 4 cycles
    cyc("lda_fhi", 0, 1, 1, 0, LDA, X_FHI);
    cyc("lda_flo", 0, 1, 1, 0, LDA, X_FLO);
    cyc("lda_dec", 0, 1, 1, 0, LDA, O_NONE);
    cyc("lda_exec", 0, 1, 1, 0, LDA, O_RD | O_LACC);

    // STO with three EXEC stalls
    cyc("sto_fhi", 0, 1, 1, 0, STO, X_FHI);
    cyc("sto_flo", 0, 1, 1, 0, STO, X_FLO);
    cyc("sto_dec", 0, 1, 1, 0, STO, O_NONE);
    for (int i = 0; i < 3; i++) cyc("sto_stall", 0, 1, 0, 0, STO, O_WR | O_DCE);
    cyc("sto_done", 0, 1, 1, 0, STO, O_WR | O_DCE);

    // SKZ taken: four inc_pc pulses
    cyc("skz1_fhi", 0, 1, 1, 1, SKZ, X_FHI);
    cyc("skz1_flo", 0, 1, 1, 1, SKZ, X_FLO);
    cyc("skz1_dec", 0, 1, 1, 1, SKZ, O_NONE);
    cyc("skz1_exec", 0, 1, 1, 1, SKZ, O_INC);
    cyc("skz1_skip", 0, 1, 1, 1, SKZ, O_INC);

    // SKZ not taken
    cyc("skz0_fhi", 0, 1, 1, 0, SKZ, X_FHI);
    cyc("skz0_flo", 0, 1, 1, 0, SKZ, X_FLO);
    cyc("skz0_dec", 0, 1, 1, 0, SKZ, O_NONE);
    cyc("skz0_exec", 0, 1, 1, 0, SKZ, O_NONE);

    // JMP with ena dropped at DECODE: completes, then IDLE
    cyc("jmp_fhi", 0, 1, 1, 0, JMP, X_FHI);
    cyc("jmp_flo", 0, 1, 1, 0, JMP, X_FLO);
    cyc("jmp_dec", 0, 0, 1, 0, JMP, O_NONE);
    cyc("jmp_exec", 0, 0, 1, 0, JMP, O_LPC);
    cyc("jmp_idle", 0, 0, 1, 0, JMP, O_NONE);
    cyc("jmp_idle2", 0, 1, 1, 0, ADD, O_NONE);

    // ADD with rst asserted during an F_LO wait
    cyc("rstw_fhi", 0, 1, 1, 0, ADD, X_FHI);
    cyc("rstw_flo", 0, 1, 0, 0, ADD, O_RD);
    cyc("rstw_flo2", 1, 1, 0, 0, ADD, O_RD);
    cyc("rstw_after", 0, 1, 0, 0, ADD, O_NONE);

    // HLT: halt from cycle 4, ena ignored, cleared by rst
    cyc("hlt_fhi", 0, 1, 1, 0, HLT, X_FHI);
    cyc("hlt_flo", 0, 1, 1, 0, HLT, X_FLO);
    cyc("hlt_dec", 0, 1, 1, 0, HLT, O_NONE);
    for (int i = 0; i < 20; i++) cyc("hlt_held", 0, i[0], 1, 0, LDA, O_HALT);
    cyc("hlt_rst", 1, 0, 1, 0, LDA, O_HALT);
    cyc("hlt_cleared", 0, 1, 1, 0, LDA, O_NONE);

    // Watchdog: 8 stalls in F_HI tolerated, 9 in F_LO errors
    for (int i = 0; i < 8; i++) cyc("wd_fhi_stall", 0, 1, 0, 0, LDA, O_RD);
    cyc("wd_fhi_ok", 0, 1, 1, 0, LDA, X_FHI);
    for (int i = 0; i < 9; i++) cyc("wd_flo_stall", 0, 1, 0, 0, LDA, O_RD);
    for (int i = 0; i < 5; i++) cyc("wd_err_held", 0, i[0], i[1], 0, LDA, O_HALT | O_BERR);
    cyc("wd_err_rst", 1, 0, 1, 0, LDA, O_HALT | O_BERR);
    cyc("wd_cleared", 0, 0, 1, 0, LDA, O_NONE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
